// File: rtl/cbc_pkg.sv
// Shared types and constants for the CBC EEPROM access path.
package cbc_pkg;

    localparam int EEP_ADDR_W    = 2;
    localparam int EEP_DATA_W    = 14;
    localparam int PUMP_3MS_800M = 2400000;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSET,
        WPUMP,
        DONE
    } eep_state_t;

    typedef enum logic {
        OWN_LOOP = 1'b0,
        OWN_CMD  = 1'b1
    } eep_owner_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eep_tmr.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module eep_tmr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/eep_arb_ctrl.sv
// EEPROM access sequencer: round-robin arbitration between control-loop reads
// and command-path reads/writes, with read hold, write pump hold and deselect.
module eep_arb_ctrl
    import cbc_pkg::*;
#(
    parameter int PUMP_CYCLES = PUMP_3MS_800M,
    parameter int RD_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  loop_req,
    input  logic [EEP_ADDR_W-1:0] loop_addr,
    output logic                  loop_gnt,
    output logic                  loop_done,
    input  logic                  cmd_req,
    input  logic                  cmd_wr,
    input  logic [EEP_ADDR_W-1:0] cmd_addr,
    input  logic [EEP_DATA_W-1:0] cmd_wdata,
    output logic                  cmd_gnt,
    output logic                  cmd_done,
    output logic [EEP_DATA_W-1:0] rd_data,
    output logic                  busy,
    input  logic [EEP_DATA_W-1:0] eep_rd_data,
    output logic [EEP_ADDR_W-1:0] eep_addr,
    output logic [EEP_DATA_W-1:0] eep_wdata,
    output logic                  eep_cs_n,
    output logic                  eep_r_w_n,
    output logic                  chrg_pmp_en
);

    localparam int               CNT_W     = $clog2(max_int(PUMP_CYCLES, RD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PUMP_LOAD = CNT_W'(PUMP_CYCLES - 1);

    eep_state_t            state_reg, state_next;
    eep_owner_t            last_owner_reg;
    logic [EEP_ADDR_W-1:0] addr_reg;
    logic [EEP_DATA_W-1:0] wdata_reg;
    logic [EEP_DATA_W-1:0] rd_data_reg;
    logic                  loop_gnt_reg;
    logic                  cmd_gnt_reg;

    logic                  grant_loop;
    logic                  grant_cmd;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_dec;
    logic                  tmr_zero;

    // With both requesting, the side not served last wins.
    always_comb begin
        grant_loop = 1'b0;
        grant_cmd  = 1'b0;
        if (state_reg == IDLE) begin
            if (loop_req && (!cmd_req || (last_owner_reg == OWN_CMD))) begin
                grant_loop = 1'b1;
            end else if (cmd_req) begin
                grant_cmd = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        tmr_load    = 1'b0;
        tmr_val     = RD_LOAD;
        tmr_dec     = 1'b0;
        eep_cs_n    = 1'b1;
        eep_r_w_n   = 1'b1;
        chrg_pmp_en = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_loop || (grant_cmd && !cmd_wr)) begin
                    state_next = RD;
                    tmr_load   = 1'b1;
                end else if (grant_cmd) begin
                    state_next = WSET;
                end
            end
            RD: begin
                eep_cs_n = 1'b0;
                tmr_dec  = 1'b1;
                if (tmr_zero) begin
                    state_next = DONE;
                end
            end
            WSET: begin
                eep_cs_n   = 1'b0;
                eep_r_w_n  = 1'b0;
                tmr_load   = 1'b1;
                tmr_val    = PUMP_LOAD;
                state_next = WPUMP;
            end
            WPUMP: begin
                eep_cs_n    = 1'b0;
                eep_r_w_n   = 1'b0;
                chrg_pmp_en = 1'b1;
                tmr_dec     = 1'b1;
                if (tmr_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Owner fields are latched at grant so requesters may change after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_owner_reg <= OWN_CMD;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rd_data_reg    <= '0;
            loop_gnt_reg   <= 1'b0;
            cmd_gnt_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            loop_gnt_reg <= grant_loop;
            cmd_gnt_reg  <= grant_cmd;
            if (grant_loop) begin
                last_owner_reg <= OWN_LOOP;
                addr_reg       <= loop_addr;
            end else if (grant_cmd) begin
                last_owner_reg <= OWN_CMD;
                addr_reg       <= cmd_addr;
                if (cmd_wr) begin
                    wdata_reg <= cmd_wdata;
                end
            end
            if ((state_reg == RD) && tmr_zero) begin
                rd_data_reg <= eep_rd_data;
            end
        end
    end

    eep_tmr #(
        .W(CNT_W)
    ) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign loop_gnt  = loop_gnt_reg;
    assign cmd_gnt   = cmd_gnt_reg;
    assign loop_done = (state_reg == DONE) && (last_owner_reg == OWN_LOOP);
    assign cmd_done  = (state_reg == DONE) && (last_owner_reg == OWN_CMD);
    assign busy      = (state_reg != IDLE);
    assign eep_addr  = addr_reg;
    assign eep_wdata = wdata_reg;
    assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_eep_arb_ctrl.sv
// Scoreboard bench for eep_arb_ctrl: stimulus pushes expected accesses in grant
// order, a negedge monitor pops them on grant/done and checks timing and data.
module tb_eep_arb_ctrl;

    localparam int PUMP = 8;
    localparam int RDC  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        loop_req = 1'b0;
    logic [1:0]  loop_addr = '0;
    logic        loop_gnt, loop_done;
    logic        cmd_req = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [13:0] cmd_wdata = '0;
    logic        cmd_gnt, cmd_done;
    logic [13:0] rd_data;
    logic        busy;
    logic [13:0] eep_rd_data;
    logic [1:0]  eep_addr;
    logic [13:0] eep_wdata;
    logic        eep_cs_n, eep_r_w_n, chrg_pmp_en;

    eep_arb_ctrl #(
        .PUMP_CYCLES(PUMP),
        .RD_CYCLES  (RDC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loop_req   (loop_req),
        .loop_addr  (loop_addr),
        .loop_gnt   (loop_gnt),
        .loop_done  (loop_done),
        .cmd_req    (cmd_req),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_gnt    (cmd_gnt),
        .cmd_done   (cmd_done),
        .rd_data    (rd_data),
        .busy       (busy),
        .eep_rd_data(eep_rd_data),
        .eep_addr   (eep_addr),
        .eep_wdata  (eep_wdata),
        .eep_cs_n   (eep_cs_n),
        .eep_r_w_n  (eep_r_w_n),
        .chrg_pmp_en(chrg_pmp_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          own;
        bit          wr;
        logic [1:0]  addr;
        logic [13:0] wdata;
        logic [13:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] mem_ref [4];
    bit          last_ref = 1'b1;
    bit          mon_active = 1'b0;
    bit          gap_chk = 1'b0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name, input int act, input int req);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // EEPROM behavioural model: array write during pump, combinational read.
    logic [13:0] mem_eep [4];
    logic        pre_en = 1'b0;
    logic [1:0]  pre_addr = '0;
    logic [13:0] pre_data = '0;

    initial begin : eeprom_model
        forever begin
            @(negedge clk);
            if (pre_en) mem_eep[pre_addr] = pre_data;
            else if (rst_n && chrg_pmp_en && !eep_cs_n && !eep_r_w_n) mem_eep[eep_addr] = eep_wdata;
        end
    end

    always_comb eep_rd_data = mem_eep[eep_addr];

    // Reference model: accesses complete in grant order, reads see prior writes.
    function automatic void push_exp(input bit own, input bit wr, input logic [1:0] addr,
                                     input logic [13:0] wdata);
        exp_t e;
        e.own   = own;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = mem_ref[addr];
        if (wr) mem_ref[addr] = wdata;
        exp_q.push_back(e);
        last_ref = own;
    endfunction

    function automatic void push_owner(input bit own);
        if (own) push_exp(1'b1, cmd_wr, cmd_addr, cmd_wdata);
        else     push_exp(1'b0, 1'b0, loop_addr, 14'h0);
    endfunction

    initial begin : monitor
        exp_t cur;
        int   gnt_cyc, pump_cnt, cs_cnt, hi_run;
        bit   prev_busy, had_low;
        gnt_cyc = 0; pump_cnt = 0; cs_cnt = 0; hi_run = 0;
        prev_busy = 1'b0; had_low = 1'b0;
        cur = '{own: 1'b0, wr: 1'b0, addr: 2'd0, wdata: 14'd0, rdata: 14'd0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                if (chrg_pmp_en) chk("pump_implies_cs_low_write", {eep_cs_n, eep_r_w_n}, 2'b00);
                if (!gap_chk) had_low = 1'b0;
                if (eep_cs_n) hi_run++;
                else begin
                    if (gap_chk && had_low && hi_run > 0) chk("cs_high_gap", hi_run, 2);
                    had_low = 1'b1;
                    hi_run  = 0;
                end
                if (loop_gnt || cmd_gnt) begin
                    chk("gnt_onehot", loop_gnt & cmd_gnt, 1'b0);
                    chk("gnt_after_idle_busy", prev_busy, 1'b0);
                    if (mon_active) flag("gnt_during_access", 1, 0);
                    if (exp_q.size() == 0) flag("unexpected_gnt", 1, 0);
                    else begin
                        cur = exp_q.pop_front();
                        chk("gnt_owner_is_cmd", cmd_gnt, cur.own);
                        chk("gnt_eep_addr", eep_addr, cur.addr);
                        chk("gnt_r_w_n", eep_r_w_n, !cur.wr);
                        if (cur.wr) chk("gnt_eep_wdata", eep_wdata, cur.wdata);
                        mon_active = 1'b1;
                        gnt_cyc    = cyc;
                        pump_cnt   = 0;
                        cs_cnt     = 0;
                    end
                end
                if (mon_active) begin
                    if (chrg_pmp_en) pump_cnt++;
                    if (!eep_cs_n) cs_cnt++;
                end
                if (loop_done || cmd_done) begin
                    if (!mon_active) flag("unexpected_done", 1, 0);
                    else begin
                        chk("done_owner_is_cmd", cmd_done, cur.own);
                        chk("done_latency", cyc - gnt_cyc, cur.wr ? PUMP + 1 : RDC);
                        if (cur.wr) begin
                            chk("pump_high_cycles", pump_cnt, PUMP);
                            chk("cs_low_cycles_wr", cs_cnt, PUMP + 1);
                        end else begin
                            chk("rd_data", rd_data, cur.rdata);
                            chk("cs_low_cycles_rd", cs_cnt, RDC);
                        end
                        $display("txn %0d: %s %s addr=%0d data=%h latency=%0d", done_cnt,
                                 cur.own ? "cmd " : "loop", cur.wr ? "write" : "read ",
                                 cur.addr, cur.wr ? cur.wdata : rd_data, cyc - gnt_cyc);
                        mon_active = 1'b0;
                        done_cnt++;
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_one(input logic [1:0] a, input logic [13:0] d);
        pre_addr = a;
        pre_data = d;
        mem_ref[a] = d;
        pre_en = 1'b1;
        @(negedge clk);
        #1;
        pre_en = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 200 && (busy || mon_active || exp_q.size() != 0)) begin
            step();
            i++;
        end
        if (i >= 200) begin
            flag("idle_timeout", i, 200);
            exp_q.delete();
        end
    endtask

    // n_hold = 0: each requester drops after its grant; n_hold > 0: both held for n grants.
    task automatic run(input bit do_loop, input bit do_cmd, input int n_hold);
        int start, grants;
        bit first;
        if (n_hold > 0) begin
            for (int k = 0; k < n_hold; k++) push_owner(!last_ref);
        end else begin
            first = (do_loop && do_cmd) ? !last_ref : do_cmd;
            push_owner(first);
            if (do_loop && do_cmd) push_owner(!first);
        end
        loop_req = do_loop;
        cmd_req  = do_cmd;
        start  = cyc;
        grants = 0;
        for (int i = 0; i < 300 && (loop_req || cmd_req); i++) begin
            step();
            if (loop_gnt || cmd_gnt) begin
                if (grants == 0) chk("gnt_latency", cyc - start, 1);
                grants++;
            end
            if (n_hold > 0) begin
                if (grants >= n_hold) begin
                    loop_req = 1'b0;
                    cmd_req  = 1'b0;
                end
            end else begin
                if (loop_gnt) begin
                    loop_req  = 1'b0;
                    loop_addr = 2'($urandom);
                end
                if (cmd_gnt) begin
                    cmd_req   = 1'b0;
                    cmd_wr    = 1'($urandom);
                    cmd_addr  = 2'($urandom);
                    cmd_wdata = 14'($urandom);
                end
            end
        end
        if (loop_req || cmd_req) begin
            flag("req_timeout", grants, n_hold);
            loop_req = 1'b0;
            cmd_req  = 1'b0;
        end
        wait_idle();
    endtask

    initial begin : stimulus
        int sel, pc, dc, grants;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cs_n", eep_cs_n, 1'b1);
        chk("rst_r_w_n", eep_r_w_n, 1'b1);
        chk("rst_pump", chrg_pmp_en, 1'b0);
        chk("rst_eep_addr", eep_addr, 2'd0);
        chk("rst_eep_wdata", eep_wdata, 14'd0);
        chk("rst_rd_data", rd_data, 14'd0);
        chk("rst_gnts", {loop_gnt, cmd_gnt}, 2'b00);
        chk("rst_dones", {loop_done, cmd_done}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        for (int a = 0; a < 4; a++) preload_one(2'(a), 14'($urandom));
        rst_n = 1'b1;
        step();

        // Simultaneous out of reset (loop first), then both held: loop, cmd, loop.
        loop_addr = 2'($urandom); cmd_wr = 1'b0; cmd_addr = 2'($urandom); cmd_wdata = 14'($urandom);
        run(1'b1, 1'b1, 0);
        loop_addr = 2'd2; cmd_wr = 1'b0; cmd_addr = 2'd3;
        run(1'b1, 1'b1, 3);

        preload_one(2'd1, 14'h1A5A);
        loop_addr = 2'b01;
        run(1'b1, 1'b0, 0);

        cmd_wr = 1'b1; cmd_addr = 2'b11; cmd_wdata = 14'h2ABC;
        run(1'b0, 1'b1, 0);

        // Back-to-back command reads with the request held across DONE.
        preload_one(2'd0, 14'h0123);
        preload_one(2'd1, 14'h3210);
        gap_chk = 1'b1;
        cmd_wr = 1'b0; cmd_addr = 2'd0;
        push_exp(1'b1, 1'b0, 2'd0, 14'h0);
        push_exp(1'b1, 1'b0, 2'd1, 14'h0);
        cmd_req = 1'b1;
        grants = 0;
        for (int i = 0; i < 100 && cmd_req; i++) begin
            step();
            if (cmd_gnt) begin
                grants++;
                if (grants == 1) cmd_addr = 2'd1;
                else cmd_req = 1'b0;
            end
        end
        if (cmd_req) begin
            flag("b2b_timeout", grants, 2);
            cmd_req = 1'b0;
        end
        wait_idle();
        gap_chk = 1'b0;

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(1, 3);
            loop_addr = 2'($urandom); cmd_wr = 1'($urandom);
            cmd_addr = 2'($urandom); cmd_wdata = 14'($urandom);
            run(sel[0], sel[1], 0);
            repeat ($urandom_range(0, 3)) step();
        end

        // Reset in the 4th pump cycle of a write.
        cmd_wr = 1'b1; cmd_addr = 2'd2; cmd_wdata = 14'h155A;
        push_exp(1'b1, 1'b1, 2'd2, 14'h155A);
        cmd_req = 1'b1;
        pc = 0;
        for (int i = 0; i < 100 && pc < 4; i++) begin
            step();
            if (cmd_gnt) cmd_req = 1'b0;
            if (chrg_pmp_en) pc++;
        end
        if (pc < 4) flag("pump_wait_timeout", pc, 4);
        cmd_req = 1'b0;
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_pump", chrg_pmp_en, 1'b0);
        chk("midrst_cs_n", eep_cs_n, 1'b1);
        chk("midrst_r_w_n", eep_r_w_n, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cmd_done", cmd_done, 1'b0);
        chk("midrst_eep_wdata", eep_wdata, 14'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (12) begin
            step();
            if (cmd_done) flag("done_after_reset", 1, 0);
        end
        chk("no_done_after_reset", done_cnt, dc);
        chk("idle_after_reset", busy, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eep_arb_ctrl.md
# eep_arb_ctrl

Sequences all EEPROM accesses in the CBC digital block and shares the single EEPROM port between two requesters: the control loop, which reads calibration constants, and the command path, which services controller read/write commands. It owns eep_cs_n, eep_r_w_n, eep_addr, the write-data bus and chrg_pmp_en. It enforces the 3 ms charge-pump hold on writes and a guaranteed deselect cycle between accesses. It sits between the command decode/control logic and the EEPROM pins at the cbc_dig level.

## Interface
- PUMP_CYCLES, 2400000, cycles chrg_pmp_en is held per write (3 ms at 800 MHz); minimum 1
- RD_CYCLES, 2, cycles chip select is held low for a read before data is captured; minimum 1
- clk  in  1  system clock, 800 MHz
- rst_n  in  1  reset, asynchronous, active-low
- loop_req  in  1  control-loop read request; level, held until loop_gnt
- loop_addr  in  2  control-loop read address
- loop_gnt  out  1  one-cycle pulse; loop request accepted
- loop_done  out  1  one-cycle pulse; rd_data valid for loop read
- cmd_req  in  1  command-path request; level, held until cmd_gnt
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  2  command address
- cmd_wdata  in  14  write data
- cmd_gnt  out  1  one-cycle pulse; command accepted
- cmd_done  out  1  one-cycle pulse; access complete (rd_data valid if read)
- rd_data  out  14  last captured read data
- busy  out  1  high in any state other than IDLE
- eep_rd_data  in  14  EEPROM read data
- eep_addr  out  2  EEPROM address
- eep_wdata  out  14  EEPROM write data
- eep_cs_n  out  1  chip select, active low
- eep_r_w_n  out  1  1 = read, 0 = write
- chrg_pmp_en  out  1  charge-pump enable

## Operation
- States: IDLE, RD, WSET, WPUMP, DONE.
- IDLE: cs_n=1, r_w_n=1, pump=0. If any request is pending, the arbiter selects an owner and latches its addr, wr and wdata. The loop owner always has wr=0. Next state is RD or WSET.
- Arbitration: round-robin on a last-owner bit. With both requesting, the requester not granted last wins. The reset value of the bit gives the loop first priority. A single requester always wins.
- RD: cs_n=0, r_w_n=1, eep_addr=latched addr, for RD_CYCLES cycles. eep_rd_data is captured into rd_data on the final RD cycle. Next state is DONE.
- WSET: cs_n=0, r_w_n=0, addr and eep_wdata driven, pump=0, for 1 cycle. Next state is WPUMP.
- WPUMP: cs_n=0, r_w_n=0, pump=1, for exactly PUMP_CYCLES cycles. Next state is DONE.
- DONE: cs_n=1, r_w_n=1, pump=0, for 1 cycle. The owner's done pulse fires here. Next state is IDLE.
- The grant pulse is asserted in the first cycle of RD/WSET. Requester inputs are don't-care after grant.
- eep_wdata updates only on a write grant and holds otherwise. rd_data updates only on read capture.
- A request still asserted in the DONE cycle is treated as a new request in the following IDLE.

## Timing
- Reset values of all outputs: eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=0, eep_addr=0, eep_wdata=0, rd_data=0, all gnt/done=0, busy=0, state=IDLE, last-owner=cmd (so the loop wins first).
- Reset asserted mid-access: outputs return to reset values immediately (async); no done pulse is issued; the pump drops at once.
- Request seen in IDLE at cycle t gives the grant at t+1.
- Read: grant at T; cs_n low T..T+RD_CYCLES-1; rd_data valid and done at T+RD_CYCLES.
- Write: grant/WSET at T; pump high T+1..T+PUMP_CYCLES; done at T+PUMP_CYCLES+1.
- Back-to-back accesses: minimum gap with cs_n=1 is 2 cycles (DONE + IDLE).
- chrg_pmp_en is never high while eep_r_w_n=1 or eep_cs_n=1.
- Counter width: $clog2(max(PUMP_CYCLES,RD_CYCLES)+1). The counter loads in the cycle before RD/WPUMP and terminates on zero, with no wrap.

## Structure
- cbc_pkg holds:
  - the eep_state_t enum (IDLE, RD, WSET, WPUMP, DONE)
  - EEP_ADDR_W=2 and EEP_DATA_W=14
  - PUMP_3MS_800M=2400000
- One sub-module, eep_tmr: a loadable down-counter with a zero flag, shared by the RD and WPUMP states.

## Test plan
Bench parameters: PUMP_CYCLES=8, RD_CYCLES=2.
- **Loop read:** loop_req addr=2'b01, eep_rd_data=14'h1A5A. Expect:
  - loop_gnt at t+1
  - cs_n low for 2 cycles, r_w_n=1
  - loop_done with rd_data=14'h1A5A exactly 2 cycles after the grant
- **Command write:** cmd_req, cmd_wr=1, addr=2'b11, wdata=14'h2ABC. Expect:
  - cmd_gnt, then r_w_n=0 with eep_wdata=14'h2ABC
  - chrg_pmp_en high exactly 8 cycles
  - cmd_done 9 cycles after the grant
- **Simultaneous requests out of reset:** loop wins first; cmd is granted after loop_done; with both held continuously, grants alternate loop, cmd, loop.
- **Reset mid-write:** assert rst_n=0 in the 4th WPUMP cycle. Expect chrg_pmp_en=0 and cs_n=1 immediately, no cmd_done, busy=0.
- **Back-to-back command reads** to addr 0 then 1: cs_n is high for exactly 2 cycles between accesses, and rd_data tracks each value.
- **Invariant check, all tests:** chrg_pmp_en=1 always implies cs_n=0 and r_w_n=0; no gnt pulse fires while busy=1 outside the first access cycle.
